// File: rtl/PARAMS_pkg.sv
// Shared widths and types for the register-file writeback path.
package PARAMS_pkg;

  localparam int INSTR_REG_BITS  = 5;
  localparam int WD_SIZE         = 32;
  localparam int STARVE_CNT_BITS = 4;

  // Requester slots in grant / ready vectors
  localparam int NUM_REQ = 2;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic {
    MEM_PRIO = 1'b0,
    ALU_PRIO = 1'b1
  } wb_prio_e;

endpackage

// File: rtl/wb_prio_fsm.sv
// Writeback priority FSM: MEM wins conflicts until ALU has lost
// STARVE_LIMIT consecutive conflicts, then ALU gets one guaranteed win.
module wb_prio_fsm
  import PARAMS_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               alu_req,
  input  logic               mem_req,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [STARVE_CNT_BITS-1:0] LIMIT = STARVE_CNT_BITS'(STARVE_LIMIT);

  wb_prio_e                   state_reg, state_next;
  logic [STARVE_CNT_BITS-1:0] starve_cnt_reg, starve_cnt_next;
  logic                       conflict;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= MEM_PRIO;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    grant           = '0;
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    conflict        = alu_req && mem_req;

    if (conflict) begin
      if (state_reg == ALU_PRIO) grant[REQ_ALU] = 1'b1;
      else                       grant[REQ_MEM] = 1'b1;
    end else begin
      grant[REQ_ALU] = alu_req;
      grant[REQ_MEM] = mem_req;
    end

    case (state_reg)
      MEM_PRIO: begin
        if (grant[REQ_ALU]) begin
          starve_cnt_next = '0;
        end else if (conflict) begin
          // Reaching the limit hands priority over, so the count never wraps
          if (starve_cnt_reg >= LIMIT - 1'b1) begin
            state_next      = ALU_PRIO;
            starve_cnt_next = '0;
          end else begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
          end
        end
      end
      ALU_PRIO: begin
        if (grant[REQ_ALU]) begin
          state_next      = MEM_PRIO;
          starve_cnt_next = '0;
        end else if (!alu_req) begin
          state_next = MEM_PRIO;
        end
      end
      default: begin
        state_next      = MEM_PRIO;
        starve_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single register-file port.
// Optional macro RF_WB_BYPASS_EN adds byp_* forwarding outputs.
module rf_wb_arbiter
  import PARAMS_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [INSTR_REG_BITS-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [INSTR_REG_BITS-1:0] mem_rd,
  input  logic [WD_SIZE-1:0]        mem_data,
  output logic                      mem_ready,
  output logic [INSTR_REG_BITS-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data
`ifdef RF_WB_BYPASS_EN
  ,
  output logic                      byp_valid,
  output logic [INSTR_REG_BITS-1:0] byp_rd,
  output logic [WD_SIZE-1:0]        byp_data
`endif
);

  logic [NUM_REQ-1:0]        valid_vec, zero_rd, req, ready_vec, grant;
  logic [INSTR_REG_BITS-1:0] rd_arr   [NUM_REQ];
  logic [WD_SIZE-1:0]        data_arr [NUM_REQ];

  logic [INSTR_REG_BITS-1:0] wr_rd_reg, wr_rd_next;
  logic [WD_SIZE-1:0]        wr_data_reg, wr_data_next;

  assign valid_vec[REQ_ALU] = alu_valid;
  assign valid_vec[REQ_MEM] = mem_valid;
  assign rd_arr[REQ_ALU]    = alu_rd;
  assign rd_arr[REQ_MEM]    = mem_rd;
  assign data_arr[REQ_ALU]  = alu_data;
  assign data_arr[REQ_MEM]  = mem_data;

  // rd = 0 requests are swallowed: ready without competing for the port
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign zero_rd[gi]   = (rd_arr[gi] == '0);
      assign req[gi]       = reset_n && valid_vec[gi] && !zero_rd[gi];
      assign ready_vec[gi] = reset_n && valid_vec[gi] && (zero_rd[gi] || grant[gi]);
    end
  endgenerate

  assign alu_ready = ready_vec[REQ_ALU];
  assign mem_ready = ready_vec[REQ_MEM];

  wb_prio_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .alu_req (req[REQ_ALU]),
    .mem_req (req[REQ_MEM]),
    .grant   (grant)
  );

  always_comb begin
    wr_rd_next   = '0;
    wr_data_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wr_rd_next   = rd_arr[i];
        wr_data_next = data_arr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_rd_reg   <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_rd_reg   <= wr_rd_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign wr_rd   = wr_rd_reg;
  assign wr_data = wr_data_reg;

`ifdef RF_WB_BYPASS_EN
  assign byp_valid = (wr_rd_reg != '0);
  assign byp_rd    = wr_rd_reg;
  assign byp_data  = wr_data_reg;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_LIMIT = 4).
module tb_rf_wb_arbiter;
  import PARAMS_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      alu_valid, mem_valid;
  logic [INSTR_REG_BITS-1:0] alu_rd, mem_rd;
  logic [WD_SIZE-1:0]        alu_data, mem_data;
  logic                      alu_ready, mem_ready;
  logic [INSTR_REG_BITS-1:0] wr_rd;
  logic [WD_SIZE-1:0]        wr_data;
`ifdef RF_WB_BYPASS_EN
  logic                      byp_valid;
  logic [INSTR_REG_BITS-1:0] byp_rd;
  logic [WD_SIZE-1:0]        byp_data;
`endif

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wr_rd     (wr_rd),
    .wr_data   (wr_data)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_valid (byp_valid),
    .byp_rd    (byp_rd),
    .byp_data  (byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 5'd2, 32'h1111, 1'b1, 5'd6, 32'h2222);
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready act=%0b exp=0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready act=%0b exp=0", mem_ready); end
    step(); step();
    checks++; if (wr_rd !== 5'd0) begin errors++; $display("FAIL reset_wr_rd act=%0d exp=0", wr_rd); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data act=%0h exp=0", wr_data); end
    checks++; if (u_dut.u_fsm.state_reg !== MEM_PRIO) begin errors++; $display("FAIL reset_state act=%0d exp=0", u_dut.u_fsm.state_reg); end
    checks++; if (u_dut.u_fsm.starve_cnt_reg !== 4'd0) begin errors++; $display("FAIL reset_cnt act=%0d exp=0", u_dut.u_fsm.starve_cnt_reg); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_alu_only();
    drive(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_only_ready act=%0b exp=1", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL alu_only_mem_ready act=%0b exp=0", mem_ready); end
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (wr_rd !== 5'd5) begin errors++; $display("FAIL alu_only_wr_rd act=%0d exp=5", wr_rd); end
    checks++; if (wr_data !== 32'hDEAD) begin errors++; $display("FAIL alu_only_wr_data act=%0h exp=dead", wr_data); end
    step();
    checks++; if (wr_rd !== 5'd0) begin errors++; $display("FAIL alu_only_idle_rd act=%0d exp=0", wr_rd); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL alu_only_idle_data act=%0h exp=0", wr_data); end
    $display("txn alu_only rd=5 data=dead");
  endtask

  task automatic test_conflict();
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd7, 32'hB7);
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL conflict_mem_ready act=%0b exp=1", mem_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL conflict_alu_ready act=%0b exp=0", alu_ready); end
    step();
    drive(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0);
    checks++; if (wr_rd !== 5'd7 || wr_data !== 32'hB7) begin errors++; $display("FAIL conflict_wr_mem act=%0d/%0h exp=7/b7", wr_rd, wr_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL conflict_alu_second act=%0b exp=1", alu_ready); end
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (wr_rd !== 5'd3 || wr_data !== 32'hA3) begin errors++; $display("FAIL conflict_wr_alu act=%0d/%0h exp=3/a3", wr_rd, wr_data); end
    step();
    $display("txn conflict mem rd=7 then alu rd=3");
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 6; i++) begin
      logic exp_alu;
      exp_alu = (i == 4);
      drive(1'b1, 5'd3, 32'hA0 + i, 1'b1, 5'd7, 32'hB0 + i);
      checks++;
      if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
        errors++;
        $display("FAIL starve_grant_%0d act=alu%0b/mem%0b exp=alu%0b/mem%0b", i, alu_ready, mem_ready, exp_alu, !exp_alu);
      end
      step();
      checks++;
      if (wr_rd !== (exp_alu ? 5'd3 : 5'd7)) begin
        errors++;
        $display("FAIL starve_wr_%0d act=%0d exp=%0d", i, wr_rd, exp_alu ? 3 : 7);
      end
    end
    checks++; if (u_dut.u_fsm.starve_cnt_reg !== 4'd1) begin errors++; $display("FAIL starve_cnt_end act=%0d exp=1", u_dut.u_fsm.starve_cnt_reg); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    $display("txn starvation mem x4 alu x1 mem x1");
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd9, 32'h99);
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rd_zero_ready act=alu%0b/mem%0b exp=alu1/mem1", alu_ready, mem_ready); end
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (wr_rd !== 5'd9 || wr_data !== 32'h99) begin errors++; $display("FAIL rd_zero_wr act=%0d/%0h exp=9/99", wr_rd, wr_data); end
    checks++; if (u_dut.u_fsm.starve_cnt_reg !== 4'd1) begin errors++; $display("FAIL rd_zero_cnt act=%0d exp=1", u_dut.u_fsm.starve_cnt_reg); end
    step();
    $display("txn rd_zero alu discarded mem rd=9");
  endtask

  task automatic test_alu_prio_drop();
    // count is 1 on entry, so three more lost conflicts reach the limit
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 32'hC3, 1'b1, 5'd8 + i, 32'hD0 + i);
      step();
    end
    checks++; if (u_dut.u_fsm.state_reg !== ALU_PRIO) begin errors++; $display("FAIL drop_enter_alu_prio act=%0d exp=1", u_dut.u_fsm.state_reg); end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hEE);
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL drop_mem_alone act=alu%0b/mem%0b exp=alu0/mem1", alu_ready, mem_ready); end
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (u_dut.u_fsm.state_reg !== MEM_PRIO) begin errors++; $display("FAIL drop_back_mem_prio act=%0d exp=0", u_dut.u_fsm.state_reg); end
    checks++; if (wr_rd !== 5'd11) begin errors++; $display("FAIL drop_wr act=%0d exp=11", wr_rd); end
    step();
    $display("txn alu_prio exit on alu drop");
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready act=%0b exp=0", mem_ready); end
    step();
    checks++; if (wr_rd !== 5'd0) begin errors++; $display("FAIL reset_mid_wr act=%0d exp=0", wr_rd); end
    checks++; if (u_dut.u_fsm.state_reg !== MEM_PRIO) begin errors++; $display("FAIL reset_mid_state act=%0d exp=0", u_dut.u_fsm.state_reg); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset_n = 1'b1;
    step();
    $display("txn reset_mid pending mem dropped");
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 32'h0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (wr_rd !== 5'd12) begin errors++; $display("FAIL bypass_wr act=%0d exp=12", wr_rd); end
    checks++; if (byp_valid !== 1'b1 || byp_rd !== 5'd12 || byp_data !== 32'h55) begin errors++; $display("FAIL bypass_out act=%0b/%0d/%0h exp=1/12/55", byp_valid, byp_rd, byp_data); end
    step();
    checks++; if (byp_valid !== 1'b0) begin errors++; $display("FAIL bypass_idle act=%0b exp=0", byp_valid); end
    $display("txn bypass rd=12 data=55");
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    #2;
    test_reset();
    test_alu_only();
    test_conflict();
    test_starvation();
    test_rd_zero();
    test_alu_prio_drop();
    test_reset_mid();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive ALU losses that forces ALU priority (legal range 1..15).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_rd  input  INSTR_REG_BITS  ALU destination register.
REQ-006 alu_data  input  WD_SIZE  ALU result.
REQ-007 alu_ready  output  1  ALU request accepted this cycle.
REQ-008 mem_valid  input  1  load-unit writeback request.
REQ-009 mem_rd  input  INSTR_REG_BITS  load destination register.
REQ-010 mem_data  input  WD_SIZE  load result.
REQ-011 mem_ready  output  1  load request accepted this cycle.
REQ-012 wr_rd  output  INSTR_REG_BITS  register-file write index, registered.
REQ-013 wr_data  output  WD_SIZE  register-file write data, registered.

Function
REQ-014 The block shall share the single register-file write port; a write occurs only via wr_rd != 0, and an idle port shall drive wr_rd = 0 and wr_data = 0.
REQ-015 Handshake: a transfer occurs when valid && ready; requesters shall hold rd/data stable while valid && !ready; ready shall be combinational from valid, rd and priority state.
REQ-016 A request with rd = 0 shall be accepted immediately (ready = 1), discarded, and not consume the write slot or affect the starvation counter.
REQ-017 With exactly one requester valid with nonzero rd, it shall be accepted the same cycle.
REQ-018 With both valid with nonzero rd, the priority-state winner shall be accepted and the loser's ready shall be 0.
REQ-019 The accepted request shall appear on wr_rd/wr_data on the cycle after acceptance (latency 1), for exactly one cycle.
REQ-020 Priority FSM states: MEM_PRIO (MEM wins conflicts) and ALU_PRIO (ALU wins conflicts).
REQ-021 In MEM_PRIO, each conflict cycle in which ALU loses shall increment starve_cnt; when starve_cnt reaches STARVE_LIMIT the FSM shall move to ALU_PRIO and clear starve_cnt.
REQ-022 Any cycle in which ALU is accepted shall clear starve_cnt.
REQ-023 In ALU_PRIO, after one ALU acceptance the FSM shall return to MEM_PRIO; if ALU valid drops without acceptance it shall also return to MEM_PRIO.
REQ-024 starve_cnt shall saturate at STARVE_LIMIT and never wrap.
REQ-025 The block shall provide no ordering between requesters targeting the same rd; issue logic guarantees no same-rd conflict is outstanding.

Reset
REQ-026 While reset_n = 0 at a clock edge: wr_rd = 0, wr_data = 0, FSM = MEM_PRIO, starve_cnt = 0.
REQ-027 While reset_n = 0, alu_ready and mem_ready shall be 0 combinationally, and any request pending at reset assertion shall be dropped without a write.

Configuration
REQ-028 Macro RF_WB_BYPASS_EN: when defined, outputs byp_valid (1), byp_rd (INSTR_REG_BITS), byp_data (WD_SIZE) shall exist and equal, respectively, (wr_rd != 0), wr_rd and wr_data, so decode forwards a value written this edge.
REQ-029 Without RF_WB_BYPASS_EN those ports shall not exist and behaviour shall otherwise be identical.

Structure
REQ-030 PARAMS_pkg shall supply INSTR_REG_BITS and WD_SIZE, and shall gain the typedef wb_prio_e {MEM_PRIO, ALU_PRIO} and the constant STARVE_CNT_BITS = 4.
REQ-031 The arbitration/starvation logic shall be a sub-module wb_prio_fsm (inputs both qualified requests, outputs grant vector); the output register stays in rf_wb_arbiter.

Verification
REQ-032 ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEAD -> alu_ready=1 same cycle; wr_rd=5, wr_data=0xDEAD next cycle; then wr_rd=0.
REQ-033 Conflict: both valid, alu_rd=3, mem_rd=7 -> mem accepted, wr_rd=7; ALU accepted next cycle, wr_rd=3.
REQ-034 Starvation, STARVE_LIMIT=4: ALU and MEM continuously valid with nonzero rd -> MEM wins 4 cycles, ALU wins the 5th, MEM wins the 6th.
REQ-035 rd=0: alu_rd=0 and mem_rd=9 both valid -> both ready=1 same cycle; wr_rd=9 next cycle; starve_cnt unchanged.
REQ-036 Reset mid-operation: assert reset_n=0 while mem_valid=1, mem_rd=4 -> mem_ready=0, wr_rd=0 after the edge, FSM=MEM_PRIO.
REQ-037 With RF_WB_BYPASS_EN: ALU write rd=12 data=0x55 -> byp_valid=1, byp_rd=12, byp_data=0x55 in the same cycle as wr_rd=12.
